multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/cpu_pkg.sv | 88 ++++++++
 rtl/insn_decode.sv | 101 ++++++++++
 rtl/multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multicycle controller.
//   state_e   controller FSM states
//   alu_op_e  encoded ALU operation driven on alu_op (0 = none)
//   kind_e    instruction class: selects the state that follows DECODE
//   ctrl_t    decoded control vector produced by insn_decode
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        LIT,
        MEM_WAIT,
        HALT,
        FAULT
    } state_e;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_PASS = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_SHL  = 4'd8,
        ALU_NEG  = 4'd9
    } alu_op_e;

    // Primary opcode field [15:12]
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_EXT = 4'hF;

    // Extended opcode field [11:8] when [15:12] = F
    localparam logic [3:0] EXT_MOV = 4'h1;
    localparam logic [3:0] EXT_CMP = 4'h2;
    localparam logic [3:0] EXT_JMP = 4'h3;
    localparam logic [3:0] EXT_LDM = 4'h4;
    localparam logic [3:0] EXT_STM = 4'h5;
    localparam logic [3:0] EXT_NEG = 4'h6;
    localparam logic [3:0] EXT_SYS = 4'hF;

    // System opcode field [7:4] when [15:8] = FF
    localparam logic [3:0] SYS_LDL  = 4'h1;
    localparam logic [3:0] SYS_GTF  = 4'h2;
    localparam logic [3:0] SYS_STF  = 4'h3;
    localparam logic [3:0] SYS_MISC = 4'hF;

    // [3:0] when [15:4] = FFF
    localparam logic [3:0] MISC_HLT = 4'h0;
    localparam logic [3:0] MISC_NOP = 4'hF;

    typedef enum logic [2:0] {
        K_EXEC,   // completes in DECODE
        K_LDL,    // literal word follows
        K_LDM,    // memory read
        K_STM,    // memory write
        K_GTF,    // flags onto d_bus
        K_HLT,
        K_BAD
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic       r1_rd;
        logic [3:0] r1_addr;
        logic       r2_rd;
        logic [3:0] r2_addr;
        logic       r3_wr;
        logic [3:0] r3_addr;
        alu_op_e    alu_op;
        logic       cmp_load;
        logic       cmp_compare;
        logic       jump;
        logic       jump_always;
        logic [3:0] jump_flag;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Register-register opcodes 1..7 map onto ALU_ADD..ALU_SHL in order.
    function automatic alu_op_e alu_from_opcode(input logic [3:0] op);
        return alu_op_e'(op + 4'd1);
    endfunction

endpackage

// File: rtl/insn_decode.sv
// insn_decode: purely combinational instruction decoder.
//   insn      in   16-bit instruction word
//   ctrl_vec  out  packed ctrl_t control vector
module insn_decode
    import cpu_pkg::*;
(
    input  logic [15:0]       insn,
    output logic [CTRL_W-1:0] ctrl_vec
);

    ctrl_t      c;
    logic [3:0] op, fa, fb, fc;

    assign op = insn[15:12];
    assign fa = insn[11:8];
    assign fb = insn[7:4];
    assign fc = insn[3:0];

    always_comb begin
        c        = '0;
        c.kind   = K_BAD;
        c.alu_op = ALU_NONE;
        if (op >= OP_ADD && op <= OP_SHL) begin
            c.kind    = K_EXEC;
            c.r1_rd   = 1'b1;
            c.r1_addr = fa;
            c.r2_rd   = 1'b1;
            c.r2_addr = fb;
            c.r3_wr   = 1'b1;
            c.r3_addr = fc;
            c.alu_op  = alu_from_opcode(op);
        end else if (op == OP_EXT) begin
            unique case (fa)
                EXT_MOV, EXT_NEG: begin
                    c.kind    = K_EXEC;
                    c.r1_rd   = 1'b1;
                    c.r1_addr = fb;
                    c.r3_wr   = 1'b1;
                    c.r3_addr = fc;
                    c.alu_op  = (fa == EXT_NEG) ? ALU_NEG : ALU_PASS;
                end
                EXT_CMP: begin
                    c.kind        = K_EXEC;
                    c.r1_rd       = 1'b1;
                    c.r1_addr     = fb;
                    c.r2_rd       = 1'b1;
                    c.r2_addr     = fc;
                    c.cmp_compare = 1'b1;
                end
                EXT_JMP: begin
                    c.kind        = K_EXEC;
                    c.r1_rd       = 1'b1;
                    c.r1_addr     = fb;
                    c.alu_op      = ALU_PASS;
                    c.jump        = 1'b1;
                    c.jump_always = (fc == 4'hF);
                    c.jump_flag   = fc;
                end
                EXT_LDM: begin
                    c.kind    = K_LDM;
                    c.r1_rd   = 1'b1;
                    c.r1_addr = fb;
                end
                EXT_STM: begin
                    c.kind    = K_STM;
                    c.r1_rd   = 1'b1;
                    c.r1_addr = fb;
                    c.r2_rd   = 1'b1;
                    c.r2_addr = fc;
                end
                EXT_SYS: begin
                    unique case (fb)
                        SYS_LDL: c.kind = K_LDL;
                        SYS_GTF: begin
                            c.kind    = K_GTF;
                            c.r3_wr   = 1'b1;
                            c.r3_addr = fc;
                        end
                        SYS_STF: begin
                            c.kind     = K_EXEC;
                            c.r1_rd    = 1'b1;
                            c.r1_addr  = fc;
                            c.cmp_load = 1'b1;
                        end
                        SYS_MISC: begin
                            if (fc == MISC_NOP)
                                c.kind = K_EXEC;
                            else if (fc == MISC_HLT)
                                c.kind = K_HLT;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign ctrl_vec = c;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle instruction sequencer for a simple datapath.
//   clk, rst_n                     clock, async active-low reset
//   i_bus                          instruction/literal word at current PC
//   flags                          comparator flag word
//   mem_ready                      memory completion strobe
//   d_bus, d_bus_oe                literal/flags value and its source select
//   mem_read, mem_write            memory requests, held while waiting
//   pc_increment, pc_load          PC controls
//   cmp_load, cmp_compare          comparator controls
//   alu_op                         encoded ALU operation
//   reg1/2_read, reg3_write, addrs register file controls
//   halted, fault                  sticky status
// Every output is registered: the output process computes the value each
// output takes after the next edge, from the current state and inputs.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_bus,
    input  logic [DATA_W-1:0] flags,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] d_bus,
    output logic              d_bus_oe,
    output logic              mem_read,
    output logic              mem_write,
    output logic              pc_increment,
    output logic              pc_load,
    output logic              cmp_load,
    output logic              cmp_compare,
    output logic [3:0]        alu_op,
    output logic              reg1_read,
    output logic              reg2_read,
    output logic              reg3_write,
    output logic [3:0]        reg1_addr,
    output logic [3:0]        reg2_addr,
    output logic [3:0]        reg3_addr,
    output logic              halted,
    output logic              fault
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_e            state, state_nx;
    logic [15:0]       ir;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wait_last;
    logic [CTRL_W-1:0] ctrl_vec;
    ctrl_t             ctrl;

    logic [DATA_W-1:0] d_bus_d;
    logic              d_bus_oe_d, mem_read_d, mem_write_d, pc_inc_d, pc_load_d;
    logic              cmp_load_d, cmp_compare_d, r1_rd_d, r2_rd_d, r3_wr_d;
    logic              halted_d, fault_d;
    logic [3:0]        r1_addr_d, r2_addr_d, r3_addr_d;
    alu_op_e           alu_d;

    insn_decode u_decode (
        .insn     (ir),
        .ctrl_vec (ctrl_vec)
    );

    assign ctrl      = ctrl_t'(ctrl_vec);
    assign wait_last = (wait_cnt == CNT_W'(WAIT_MAX - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   state_nx = FETCH;
            FETCH:  state_nx = DECODE;
            DECODE: begin
                unique case (ctrl.kind)
                    K_LDL:        state_nx = LIT;
                    K_LDM, K_STM: state_nx = MEM_WAIT;
                    K_HLT:        state_nx = HALT;
                    K_BAD:        state_nx = FAULT;
                    default:      state_nx = FETCH;
                endcase
            end
            LIT:      state_nx = FETCH;
            MEM_WAIT: begin
                // A ready on the final tolerated cycle still completes.
                if (mem_ready)      state_nx = FETCH;
                else if (wait_last) state_nx = FAULT;
            end
            default: ;
        endcase
    end

    // Output logic (values presented after the next edge)
    always_comb begin
        d_bus_d       = '0;
        d_bus_oe_d    = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        pc_inc_d      = 1'b0;
        pc_load_d     = 1'b0;
        cmp_load_d    = 1'b0;
        cmp_compare_d = 1'b0;
        r1_rd_d       = 1'b0;
        r2_rd_d       = 1'b0;
        r3_wr_d       = 1'b0;
        r1_addr_d     = '0;
        r2_addr_d     = '0;
        r3_addr_d     = '0;
        alu_d         = ALU_NONE;
        halted_d      = 1'b0;
        fault_d       = 1'b0;
        unique case (state)
            FETCH: pc_inc_d = 1'b1;
            DECODE: begin
                r1_rd_d       = ctrl.r1_rd;
                r1_addr_d     = ctrl.r1_addr;
                r2_rd_d       = ctrl.r2_rd;
                r2_addr_d     = ctrl.r2_addr;
                r3_wr_d       = ctrl.r3_wr;
                r3_addr_d     = ctrl.r3_addr;
                alu_d         = ctrl.alu_op;
                cmp_load_d    = ctrl.cmp_load;
                cmp_compare_d = ctrl.cmp_compare;
                pc_load_d     = ctrl.jump && (ctrl.jump_always || flags[ctrl.jump_flag]);
                unique case (ctrl.kind)
                    K_LDL: pc_inc_d    = 1'b1;
                    K_LDM: mem_read_d  = 1'b1;
                    K_STM: mem_write_d = 1'b1;
                    K_GTF: begin
                        d_bus_oe_d = 1'b1;
                        d_bus_d    = flags;
                    end
                    K_HLT: halted_d = 1'b1;
                    K_BAD: fault_d  = 1'b1;
                    default: ;
                endcase
            end
            LIT: begin
                d_bus_oe_d = 1'b1;
                d_bus_d    = i_bus;
                r3_wr_d    = 1'b1;
                r3_addr_d  = ir[3:0];
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    if (ctrl.kind == K_LDM) begin
                        r3_wr_d   = 1'b1;
                        r3_addr_d = ir[3:0];
                    end
                end else if (wait_last) begin
                    fault_d = 1'b1;
                end else begin
                    mem_read_d  = (ctrl.kind == K_LDM);
                    mem_write_d = (ctrl.kind == K_STM);
                end
            end
            HALT:  halted_d = 1'b1;
            FAULT: fault_d  = 1'b1;
            default: ;
        endcase
    end

    // Instruction register and memory-wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == FETCH)
                ir <= i_bus[15:0];
            if (state == MEM_WAIT && !mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_bus        <= '0;
            d_bus_oe     <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            pc_increment <= 1'b0;
            pc_load      <= 1'b0;
            cmp_load     <= 1'b0;
            cmp_compare  <= 1'b0;
            alu_op       <= '0;
            reg1_read    <= 1'b0;
            reg2_read    <= 1'b0;
            reg3_write   <= 1'b0;
            reg1_addr    <= '0;
            reg2_addr    <= '0;
            reg3_addr    <= '0;
            halted       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            d_bus        <= d_bus_d;
            d_bus_oe     <= d_bus_oe_d;
            mem_read     <= mem_read_d;
            mem_write    <= mem_write_d;
            pc_increment <= pc_inc_d;
            pc_load      <= pc_load_d;
            cmp_load     <= cmp_load_d;
            cmp_compare  <= cmp_compare_d;
            alu_op       <= alu_d;
            reg1_read    <= r1_rd_d;
            reg2_read    <= r2_rd_d;
            reg3_write   <= r3_wr_d;
            reg1_addr    <= r1_addr_d;
            reg2_addr    <= r2_addr_d;
            reg3_addr    <= r3_addr_d;
            halted       <= halted_d;
            fault        <= fault_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. A small program
// memory feeds i_bus from a bench-side PC; a memory responder raises
// mem_ready after a programmable number of request cycles (0 = never).
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    typedef struct packed {
        logic       r1;
        logic [3:0] a1;
        logic       r2;
        logic [3:0] a2;
        logic       w3;
        logic [3:0] a3;
        logic [3:0] op;
        logic       oe;
        logic [15:0] d;
        logic       pcl;
        logic       cc;
        logic       cl;
    } ev_t;

    typedef struct {
        string tag;
        ev_t   ev;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_bus, flags = '0;
    logic        mem_ready;
    logic [15:0] d_bus;
    logic        d_bus_oe, mem_read, mem_write, pc_increment, pc_load;
    logic        cmp_load, cmp_compare, reg1_read, reg2_read, reg3_write;
    logic [3:0]  alu_op, reg1_addr, reg2_addr, reg3_addr;
    logic        halted, fault;

    logic [15:0] prog [0:63];
    logic [5:0]  pc;
    logic [15:0] pq [$];
    sb_t         sb [$];

    int unsigned mem_lat = 0;
    bit          stray_rdy = 1'b0;
    int unsigned req_cnt;
    int unsigned n_checks = 0, n_fail = 0;
    int unsigned inc_cnt, rd_cycles, wr_cycles, first_inc, first_ev;

    multicycle_ctrl #(.DATA_W(16), .WAIT_MAX(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bus        (i_bus),
        .flags        (flags),
        .mem_ready    (mem_ready),
        .d_bus        (d_bus),
        .d_bus_oe     (d_bus_oe),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .pc_increment (pc_increment),
        .pc_load      (pc_load),
        .cmp_load     (cmp_load),
        .cmp_compare  (cmp_compare),
        .alu_op       (alu_op),
        .reg1_read    (reg1_read),
        .reg2_read    (reg2_read),
        .reg3_write   (reg3_write),
        .reg1_addr    (reg1_addr),
        .reg2_addr    (reg2_addr),
        .reg3_addr    (reg3_addr),
        .halted       (halted),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    assign i_bus = prog[pc];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pc <= '0;
        else if (pc_increment) pc <= pc + 6'd1;
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt   <= 0;
            mem_ready <= 1'b0;
        end else if (mem_read || mem_write) begin
            req_cnt   <= req_cnt + 1;
            mem_ready <= (mem_lat != 0) && (req_cnt + 1 == mem_lat);
        end else begin
            req_cnt   <= 0;
            mem_ready <= stray_rdy;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ev_t mk_ev(input logic r1, input logic [3:0] a1,
                                  input logic r2, input logic [3:0] a2,
                                  input logic w3, input logic [3:0] a3,
                                  input logic [3:0] op, input logic oe, input logic [15:0] d,
                                  input logic pcl, input logic cc, input logic cl);
        ev_t e;
        e = '{r1:r1, a1:a1, r2:r2, a2:a2, w3:w3, a3:a3, op:op, oe:oe, d:d,
              pcl:pcl, cc:cc, cl:cl};
        return e;
    endfunction

    task automatic push(input string tag, input ev_t e);
        sb_t s;
        s.tag = tag;
        s.ev  = e;
        sb.push_back(s);
    endtask

    task automatic load_prog();
        foreach (prog[i]) prog[i] = 16'hFFF0;
        foreach (pq[i]) prog[i] = pq[i];
    endtask

    // Reset, release, then watch ncyc cycles; every strobe cycle pops one
    // expected event from the scoreboard.
    task automatic run_scn(input string name, input int unsigned lat, input bit stray,
                           input logic [15:0] fl, input int unsigned ncyc,
                           input int unsigned exp_inc);
        ev_t g;
        sb_t e;
        rst_n     = 1'b0;
        mem_lat   = lat;
        stray_rdy = stray;
        flags     = fl;
        load_prog();
        inc_cnt = 0; rd_cycles = 0; wr_cycles = 0; first_inc = 0; first_ev = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (pc_increment) begin
                if (inc_cnt == 0) first_inc = k;
                inc_cnt++;
            end
            if (mem_read)  rd_cycles++;
            if (mem_write) wr_cycles++;
            if (reg1_read || reg2_read || reg3_write || pc_load || cmp_compare ||
                cmp_load || d_bus_oe) begin
                g = mk_ev(reg1_read, reg1_addr, reg2_read, reg2_addr, reg3_write, reg3_addr,
                          alu_op, d_bus_oe, d_bus, pc_load, cmp_compare, cmp_load);
                if (first_ev == 0) first_ev = k;
                if (sb.size() == 0) begin
                    check_val({name, "_unexpected_event"}, 64'(g), '0);
                end else begin
                    e = sb.pop_front();
                    check_val(e.tag, 64'(g), 64'(e.ev));
                end
            end
        end
        check_val({name, "_first_fetch_cycle"}, 64'(first_inc), 64'd2);
        check_val({name, "_pc_inc_count"}, 64'(inc_cnt), 64'(exp_inc));
        check_val({name, "_sb_drain"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_outputs",
                  {d_bus, d_bus_oe, mem_read, mem_write, pc_increment, pc_load, cmp_load,
                   cmp_compare, alu_op, reg1_read, reg2_read, reg3_write, reg1_addr,
                   reg2_addr, reg3_addr, halted, fault}, '0);

        // Register ops, mov/cmp/neg/gtf/stf/nop; stray mem_ready must be ignored
        pq = {16'h1321, 16'h2456, 16'h3789, 16'h4ABC, 16'h5DEF, 16'h6012, 16'h7345,
              16'hF1AB, 16'hF2CD, 16'hF67E, 16'hFF29, 16'hFF34, 16'hFFFF, 16'hFFF0};
        push("add", mk_ev(1, 4'h3, 1, 4'h2, 1, 4'h1, 4'd2, 0, 16'h0, 0, 0, 0));
        push("sub", mk_ev(1, 4'h4, 1, 4'h5, 1, 4'h6, 4'd3, 0, 16'h0, 0, 0, 0));
        push("and", mk_ev(1, 4'h7, 1, 4'h8, 1, 4'h9, 4'd4, 0, 16'h0, 0, 0, 0));
        push("or",  mk_ev(1, 4'hA, 1, 4'hB, 1, 4'hC, 4'd5, 0, 16'h0, 0, 0, 0));
        push("xor", mk_ev(1, 4'hD, 1, 4'hE, 1, 4'hF, 4'd6, 0, 16'h0, 0, 0, 0));
        push("shr", mk_ev(1, 4'h0, 1, 4'h1, 1, 4'h2, 4'd7, 0, 16'h0, 0, 0, 0));
        push("shl", mk_ev(1, 4'h3, 1, 4'h4, 1, 4'h5, 4'd8, 0, 16'h0, 0, 0, 0));
        push("mov", mk_ev(1, 4'hA, 0, 4'h0, 1, 4'hB, 4'd1, 0, 16'h0, 0, 0, 0));
        push("cmp", mk_ev(1, 4'hC, 1, 4'hD, 0, 4'h0, 4'd0, 0, 16'h0, 0, 1, 0));
        push("neg", mk_ev(1, 4'h7, 0, 4'h0, 1, 4'hE, 4'd9, 0, 16'h0, 0, 0, 0));
        push("gtf", mk_ev(0, 4'h0, 0, 4'h0, 1, 4'h9, 4'd0, 1, 16'hA5C3, 0, 0, 0));
        push("stf", mk_ev(1, 4'h4, 0, 4'h0, 0, 4'h0, 4'd0, 0, 16'h0, 0, 0, 1));
        run_scn("alu", 0, 1'b1, 16'hA5C3, 40, 14);
        check_val("alu_first_event_cycle", 64'(first_ev), 64'd3);
        check_val("alu_halted", 64'({halted, fault}), 64'b10);

        // Literal load: literal is the word after the ldl
        pq = {16'hFF15, 16'hBEEF, 16'hFFF0};
        push("ldl", mk_ev(0, 4'h0, 0, 4'h0, 1, 4'h5, 4'd0, 1, 16'hBEEF, 0, 0, 0));
        run_scn("ldl", 0, 1'b0, 16'h0, 12, 3);
        check_val("ldl_event_cycle", 64'(first_ev), 64'd4);
        check_val("ldl_halted", 64'({halted, fault}), 64'b10);

        // Memory read, ready on 4th wait cycle, stray ready before the request
        pq = {16'hF423, 16'hFFF0};
        push("ldm4_addr", mk_ev(1, 4'h2, 0, 4'h0, 0, 4'h0, 4'd0, 0, 16'h0, 0, 0, 0));
        push("ldm4_wr",   mk_ev(0, 4'h0, 0, 4'h0, 1, 4'h3, 4'd0, 0, 16'h0, 0, 0, 0));
        run_scn("ldm4", 4, 1'b1, 16'h0, 15, 2);
        check_val("ldm4_read_cycles", 64'(rd_cycles), 64'd4);
        check_val("ldm4_halted", 64'({halted, fault}), 64'b10);

        // Ready on the final tolerated cycle completes normally
        push("ldm15_addr", mk_ev(1, 4'h2, 0, 4'h0, 0, 4'h0, 4'd0, 0, 16'h0, 0, 0, 0));
        push("ldm15_wr",   mk_ev(0, 4'h0, 0, 4'h0, 1, 4'h3, 4'd0, 0, 16'h0, 0, 0, 0));
        run_scn("ldm15", 15, 1'b0, 16'h0, 26, 2);
        check_val("ldm15_read_cycles", 64'(rd_cycles), 64'd15);
        check_val("ldm15_halted", 64'({halted, fault}), 64'b10);

        // Memory never answers
        pq = {16'hF423};
        push("ldm_to_addr", mk_ev(1, 4'h2, 0, 4'h0, 0, 4'h0, 4'd0, 0, 16'h0, 0, 0, 0));
        run_scn("ldm_to", 0, 1'b0, 16'h0, 30, 1);
        check_val("ldm_to_read_cycles", 64'(rd_cycles), 64'd15);
        check_val("ldm_to_fault", 64'({halted, fault, mem_read}), 64'b010);

        // Memory write
        pq = {16'hF576, 16'hFFF0};
        push("stm", mk_ev(1, 4'h7, 1, 4'h6, 0, 4'h0, 4'd0, 0, 16'h0, 0, 0, 0));
        run_scn("stm", 2, 1'b0, 16'h0, 14, 2);
        check_val("stm_write_cycles", 64'(wr_cycles), 64'd2);
        check_val("stm_halted", 64'({halted, fault}), 64'b10);

        // Conditional jump on flags[2] clear (all other flags set) and set
        pq = {16'hF312, 16'hF31F, 16'hFFF0};
        push("jmp_f2_clr", mk_ev(1, 4'h1, 0, 4'h0, 0, 4'h0, 4'd1, 0, 16'h0, 0, 0, 0));
        push("jmp_always0", mk_ev(1, 4'h1, 0, 4'h0, 0, 4'h0, 4'd1, 0, 16'h0, 1, 0, 0));
        run_scn("jmp0", 0, 1'b0, 16'hFFFB, 14, 3);
        push("jmp_f2_set", mk_ev(1, 4'h1, 0, 4'h0, 0, 4'h0, 4'd1, 0, 16'h0, 1, 0, 0));
        push("jmp_always1", mk_ev(1, 4'h1, 0, 4'h0, 0, 4'h0, 4'd1, 0, 16'h0, 1, 0, 0));
        run_scn("jmp1", 0, 1'b0, 16'h0004, 14, 3);

        // Illegal encodings
        pq = {16'h0000};
        run_scn("bad0000", 0, 1'b0, 16'h0, 10, 1);
        check_val("bad0000_fault", 64'({halted, fault}), 64'b01);
        pq = {16'hF700};
        run_scn("badF700", 0, 1'b0, 16'h0, 10, 1);
        check_val("badF700_fault", 64'({halted, fault}), 64'b01);

        // Reset asserted mid memory wait
        pq = {16'hF423};
        push("rstmw_addr", mk_ev(1, 4'h2, 0, 4'h0, 0, 4'h0, 4'd0, 0, 16'h0, 0, 0, 0));
        run_scn("rstmw", 0, 1'b0, 16'h0, 6, 1);
        check_val("rstmw_pre_read", 64'(mem_read), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rstmw_mem_read", 64'(mem_read), 64'd0);
        check_val("rstmw_state", 64'(dut.state), 64'(IDLE));
        check_val("rstmw_outputs",
                  {d_bus_oe, mem_read, mem_write, pc_increment, reg1_read, reg1_addr,
                   halted, fault}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
